key_conditioner: RTL and testbench
==================================

# key_conditioner

Input conditioning stage directly upstream of `indicator_control`. It takes the two raw push-button lines, synchronises and debounces them, and drives clean `key_a`/`key_b` levels into the indicator. It also produces one-cycle press pulses with optional auto-repeat and a defined order for simultaneous presses. It contains no display logic.

## Interface
- `DEBOUNCE`, 4: consecutive synchronised samples required before a level change is accepted. Must be ≥1.
- `REPEAT_DELAY`, 16: cycles from the initial press pulse to the first repeat pulse while the key is held. 0 disables repeat.
- `REPEAT_PERIOD`, 4: cycles between subsequent repeat pulses. Must be ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `key_a_raw` in 1: raw button A, asynchronous, 1 = pressed.
- `key_b_raw` in 1: raw button B, asynchronous, 1 = pressed.
- `key_a` out 1: debounced level of A; feeds `indicator_control` key_a.
- `key_b` out 1: debounced level of B; feeds `indicator_control` key_b.
- `press_a` out 1: one-cycle pulse on accepted press of A and on each repeat.
- `press_b` out 1: one-cycle pulse on accepted press of B and on each repeat.

## Operation
- **Per key:** 2-flop synchroniser (`s1`→`s2`), debounce counter, repeat counter, and debounced level register `lvl`.
- **Debounce (every edge):**
  - If `s2 != lvl`: if `cnt == DEBOUNCE-1`, set `lvl <= s2` and `cnt <= 0`; otherwise `cnt++`.
  - If `s2 == lvl`: `cnt <= 0`.
  - Any disagreeing run shorter than `DEBOUNCE` samples is discarded.
- **Per-key states:**
  - RELEASED: `lvl`=0, `cnt`=0.
  - ARMING: `lvl`=0, `cnt`>0. Goes to PRESSED on acceptance, or back to RELEASED on a glitch.
  - PRESSED: `lvl`=1, `cnt`=0.
  - DISARMING: `lvl`=1, `cnt`>0. Goes to RELEASED on acceptance, or back to PRESSED on a glitch.
- **Press pulse:** requested on the edge where `lvl` goes 0→1. No pulse on release.
- **Repeat:**
  - While `lvl`=1 and `REPEAT_DELAY`≠0, the repeat counter runs from the press edge.
  - A repeat pulse is requested `REPEAT_DELAY` cycles after the initial request, then every `REPEAT_PERIOD` cycles.
  - The counter clears when `lvl` falls or when the key enters DISARMING. Repeat requests are suppressed in DISARMING.
- **Simultaneous requests:**
  - If A and B request a pulse on the same edge, `press_a` fires that cycle.
  - B's request is latched in `pend_b` and `press_b` fires the next cycle.
  - A pending B request is never dropped and never duplicated. A fresh B request arriving while `pend_b`=1 is merged into it.
- **Counter widths:** `$clog2` of the parameter, minimum 1 bit. Counters saturate rather than wrap.

## Timing
- **Reset:** `rst_n`=0 sampled at an edge sets the following to 0: `key_a`, `key_b`, `press_a`, `press_b`, all sync flops, counters, and `pend_b`. Outputs hold 0 for every cycle `rst_n` is low.
- **Press latency:** with raw stable from edge E0, `key_x` and `press_x` (non-conflicting) become 1 after edge E0+DEBOUNCE+1, i.e. the 6th edge when DEBOUNCE=4.
- **Release latency:** identical to press latency; `key_x` falls after edge E0+DEBOUNCE+1.
- **Press pulse width:** exactly 1 cycle.
- **Repeat timing:** repeat pulse at press pulse cycle +`REPEAT_DELAY`, then +`REPEAT_PERIOD` each.
- **Deferred B pulse:** +1 cycle relative to undeferred.
- **Reset mid-operation:** all in-flight debounce, repeat and pending state is lost. A key still held when `rst_n` rises is treated as a new press: `key_x` and `press_x` after the (DEBOUNCE+2)th edge with `rst_n`=1.
- **Toggle-rate limit:** raw toggling every cycle never changes `lvl`.

## Test plan
All scenarios use DEBOUNCE=4, REPEAT_DELAY=16, REPEAT_PERIOD=4.
1. `key_a_raw` 0→1 at edge 10, held 12 cycles, then 0 → `key_a` high from after edge 15 until after edge 27; exactly one `press_a` pulse (cycle after edge 15); `key_b`/`press_b` stay 0.
2. `key_b_raw` glitch high for 3 cycles, then 0 for 10 → `key_b`=0 and `press_b`=0 throughout.
3. `key_a_raw` held high 40 cycles from edge 10 → `press_a` after edges 15, 31, 35, 39, 43, 47; no pulses after release is accepted.
4. Both raw lines 0→1 at edge 10 → `key_a`=`key_b`=1 after edge 15; `press_a` after edge 15; `press_b` after edge 16; each exactly once before repeat.
5. `key_a` pressed and accepted; `rst_n`=0 for 3 edges with raw still 1 → all outputs 0 during reset; after `rst_n`=1, `key_a` and `press_a` return on the 6th edge.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: synchronise, debounce and auto-repeat two push buttons, with A-before-B ordering of press pulses
module key_conditioner #(
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_a_raw,
    input  logic key_b_raw,
    output logic key_a,
    output logic key_b,
    output logic press_a,
    output logic press_b
);
    localparam int DW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = RMAX > 1 ? $clog2(RMAX) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    logic [1:0] raw, level, req;
    logic pend_b;
    assign raw = {key_b_raw, key_a_raw};
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic s1, s2, lvl, seen, rise, due;
        logic [DW-1:0] cnt;
        logic [RW-1:0] rcnt;
        assign rise = !lvl && s2 && cnt == D_LAST;
        assign due = REPEAT_DELAY != 0 && rcnt == (seen ? PERIOD_LAST : DELAY_LAST);
        // repeats only from a settled PRESSED state, never while a release is being qualified
        assign req[k] = rise || (due && lvl && s2 && cnt == '0);
        assign level[k] = lvl;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                lvl  <= 1'b0;
                cnt  <= '0;
                rcnt <= '0;
                seen <= 1'b0;
            end else begin
                s1 <= raw[k];
                s2 <= s1;
                if (s2 == lvl) cnt <= '0;
                else if (cnt == D_LAST) begin
                    lvl <= s2;
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
                if (!lvl || !s2) begin
                    rcnt <= '0;
                    seen <= 1'b0;
                end else if (due) begin
                    rcnt <= '0;
                    seen <= 1'b1;
                end else if (rcnt != '1) rcnt <= rcnt + 1'b1;
            end
        end
    end
    assign key_a = level[0];
    assign key_b = level[1];
    // a B request colliding with A waits one cycle; a new B request meeting a pending one is merged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_a <= 1'b0;
            press_b <= 1'b0;
            pend_b  <= 1'b0;
        end else begin
            press_a <= req[0];
            press_b <= pend_b || (req[1] && !req[0]);
            pend_b  <= req[0] && req[1] && !pend_b;
        end
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus random button activity checked against a behavioural model
module tb_key_conditioner;
    localparam int DEB = 4;
    localparam int RD = 16;
    localparam int RP = 4;
    logic clk = 1'b0;
    logic rst_n, key_a_raw, key_b_raw;
    logic key_a, key_b, press_a, press_b;
    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;
    int qa[$];
    int qb[$];
    bit m_s1[2], m_s2[2], m_lvl[2];
    int m_run[2], m_age[2];
    bit m_pa, m_pb, m_pend;

    key_conditioner #(.DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst_n(rst_n), .key_a_raw(key_a_raw), .key_b_raw(key_b_raw),
        .key_a(key_a), .key_b(key_b), .press_a(press_a), .press_b(press_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
        end
    endtask

    // model: s2 lags raw by two edges; a level flips after DEB consecutive disagreeing samples;
    // repeats fire at hold ages RD, RD+RP, ... counted from the press or the last release attempt
    task automatic model_edge(input bit rn, input bit a, input bit b);
        bit raw[2];
        bit req[2];
        bit rise, rep;
        int age_n;
        raw[0] = a;
        raw[1] = b;
        if (!rn) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_run[k] = 0; m_age[k] = 0;
            end
            m_pa = 0; m_pb = 0; m_pend = 0;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            rise = !m_lvl[k] && m_s2[k] && m_run[k] == DEB - 1;
            age_n = (m_lvl[k] && m_s2[k]) ? m_age[k] + 1 : 0;
            rep = RD != 0 && m_lvl[k] && m_s2[k] && m_run[k] == 0 && age_n >= RD && (age_n - RD) % RP == 0;
            req[k] = rise || rep;
            if (m_s2[k] != m_lvl[k]) begin
                if (m_run[k] + 1 == DEB) begin
                    m_lvl[k] = m_s2[k];
                    m_run[k] = 0;
                end else m_run[k] = m_run[k] + 1;
            end else m_run[k] = 0;
            m_age[k] = age_n;
            m_s2[k] = m_s1[k];
            m_s1[k] = raw[k];
        end
        m_pa = req[0];
        m_pb = m_pend || (req[1] && !req[0]);
        m_pend = req[0] && req[1] && !m_pend;
    endtask

    task automatic cycle(input logic rn, input logic a, input logic b);
        rst_n = rn;
        key_a_raw = a;
        key_b_raw = b;
        @(posedge clk);
        edge_n++;
        model_edge(rn, a, b);
        @(negedge clk);
        check("key_a", key_a, m_lvl[0]);
        check("key_b", key_b, m_lvl[1]);
        check("press_a", press_a, m_pa);
        check("press_b", press_b, m_pb);
        if (press_a) qa.push_back(edge_n);
        if (press_b) qb.push_back(edge_n);
    endtask

    task automatic run(input logic rn, input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) cycle(rn, a, b);
    endtask

    task automatic start_scenario();
        edge_n = 0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        int first_key, late, ha, hb, va, vb;
        run(0, 0, 0, 3);
        // 1: single press and release of A
        start_scenario();
        run(1, 0, 0, 9);
        run(1, 1, 0, 12);
        run(1, 0, 0, 20);
        check("s1_press_a_count", qa.size(), 1);
        if (qa.size() > 0) check("s1_press_a_edge", qa[0], 15);
        check("s1_press_b_count", qb.size(), 0);
        // 2: short B glitch is rejected
        start_scenario();
        run(1, 0, 1, 3);
        run(1, 0, 0, 10);
        check("s2_press_b_count", qb.size(), 0);
        // 3: long hold of A auto-repeats
        start_scenario();
        run(1, 0, 0, 9);
        run(1, 1, 0, 40);
        run(1, 0, 0, 15);
        late = 0;
        while (qa.size() > 0 && qa[qa.size() - 1] > 49) begin
            if (qa[qa.size() - 1] > 55) late++;
            void'(qa.pop_back());
        end
        check("s3_pulses_while_held", qa.size(), 6);
        if (qa.size() == 6) begin
            check("s3_pulse0", qa[0], 15);
            check("s3_pulse1", qa[1], 31);
            check("s3_pulse2", qa[2], 35);
            check("s3_pulse5", qa[5], 47);
        end
        check("s3_after_release", late, 0);
        // 4: simultaneous press defers B by one cycle
        start_scenario();
        run(1, 0, 0, 9);
        run(1, 1, 1, 12);
        run(1, 0, 0, 20);
        check("s4_press_a_count", qa.size(), 1);
        check("s4_press_b_count", qb.size(), 1);
        if (qa.size() > 0) check("s4_press_a_edge", qa[0], 15);
        if (qb.size() > 0) check("s4_press_b_edge", qb[0], 16);
        // 5: reset while A held, then re-press after reset
        run(1, 1, 0, 10);
        run(0, 1, 0, 3);
        start_scenario();
        first_key = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1, 1, 0);
            if (key_a && first_key == 0) first_key = i;
        end
        check("s5_key_a_edge", first_key, 6);
        check("s5_press_a_count", qa.size(), 1);
        if (qa.size() > 0) check("s5_press_a_edge", qa[0], 6);
        // toggling every cycle never moves the level
        run(1, 0, 0, 20);
        start_scenario();
        for (int i = 0; i < 30; i++) cycle(1, i[0], !i[0]);
        run(1, 0, 0, 10);
        check("toggle_press_count", qa.size() + qb.size(), 0);
        // random activity with occasional reset
        ha = 0; hb = 0; va = 0; vb = 0;
        for (int i = 0; i < 5000; i++) begin
            if (ha == 0) begin
                va = $urandom_range(0, 1);
                ha = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
            end
            if (hb == 0) begin
                vb = $urandom_range(0, 1);
                hb = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
            end
            ha--;
            hb--;
            cycle($urandom_range(0, 399) != 0, va[0], vb[0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
